aes_host_sequencer: RTL and testbench

//  Host-side driver for the AesTop engine interface. Takes 128-bit blocks from a

---
 rtl/aes_host_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_aes_host_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_host_sequencer.sv
// rtl/aes_host_sequencer.sv - host-side command/response sequencer for the AesTop engine interface
//
// Accepts 128-bit blocks on a valid/ready command stream, runs key expansion on
// request, issues each block on the engine's enc or dec channel and returns the
// engine result on a valid/ready result stream.
//
// Optional feature macro: AES_HOST_TIMEOUT_EN (engine response / key expansion timeout).
//
// Ports:
//   i_clock, i_reset                 clock, synchronous active-high reset
//   i_key_load, i_key_in             1-cycle re-key request and AES-128 key
//   i_in_valid/o_in_ready            command handshake, i_in_mode (0 enc, 1 dec), i_in_data
//   o_out_valid/i_out_ready          result handshake, o_out_mode, o_out_data, o_out_err
//   o_io_key, o_io_startKeyExp       key and key-expansion start pulse to the engine
//   i_io_keyExpReady                 key expansion done level from the engine
//   o_io_encIntf_text_*              encrypt request, i_io_encIntf_cipher_* encrypt response
//   o_io_decIntf_cipher_*            decrypt request, i_io_decIntf_text_* decrypt response

module aes_host_sequencer #(
    parameter int GAP_CYCLES     = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_key_load,
    input  logic [127:0] i_key_in,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic         i_in_mode,
    input  logic [127:0] i_in_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic         o_out_mode,
    output logic [127:0] o_out_data,
    output logic         o_out_err,
    output logic [127:0] o_io_key,
    output logic         o_io_startKeyExp,
    input  logic         i_io_keyExpReady,
    output logic         o_io_encIntf_text_valid,
    output logic [127:0] o_io_encIntf_text_bits_0,
    input  logic         i_io_encIntf_cipher_valid,
    input  logic [127:0] i_io_encIntf_cipher_bits_0,
    output logic         o_io_decIntf_cipher_valid,
    output logic [127:0] o_io_decIntf_cipher_bits_0,
    input  logic         i_io_decIntf_text_valid,
    input  logic [127:0] i_io_decIntf_text_bits_0
);

    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_NOKEY,
        S_KEYSTART,
        S_KEYWAIT,
        S_READY,
        S_ISSUE,
        S_RESP
    } state_t;

    state_t         r_state;
    logic [GW-1:0]  r_gap;
    logic           r_kexp_prev;
    logic           r_enc_prev;
    logic           r_dec_prev;
    logic           r_mode;
    logic [127:0]   r_key;
    logic           r_start;
    logic           r_enc_valid;
    logic [127:0]   r_enc_bits;
    logic           r_dec_valid;
    logic [127:0]   r_dec_bits;
    logic           r_out_valid;
    logic           r_out_mode;
    logic [127:0]   r_out_data;

    logic           w_in_ready;
    logic           w_kexp_edge;
    logic           w_resp_edge;
    logic [127:0]   w_resp_bits;

    // key_load has priority over a command in READY, so it masks in_ready combinationally.
    assign w_in_ready  = (r_state == S_READY) && (r_gap == '0) && !i_key_load;
    assign w_kexp_edge = i_io_keyExpReady & ~r_kexp_prev;
    // Only the channel the block went out on can complete it.
    assign w_resp_edge = r_mode ? (i_io_decIntf_text_valid & ~r_dec_prev)
                                : (i_io_encIntf_cipher_valid & ~r_enc_prev);
    assign w_resp_bits = r_mode ? i_io_decIntf_text_bits_0 : i_io_encIntf_cipher_bits_0;

`ifdef AES_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]  r_tmo;
    logic           r_out_err;
    assign o_out_err = r_out_err;
`else
    // Always 0; the timeout parameter stays so both builds share one interface.
    assign o_out_err = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_NOKEY;
            r_gap       <= '0;
            r_kexp_prev <= 1'b0;
            r_enc_prev  <= 1'b0;
            r_dec_prev  <= 1'b0;
            r_mode      <= 1'b0;
            r_key       <= '0;
            r_start     <= 1'b0;
            r_enc_valid <= 1'b0;
            r_enc_bits  <= '0;
            r_dec_valid <= 1'b0;
            r_dec_bits  <= '0;
            r_out_valid <= 1'b0;
            r_out_mode  <= 1'b0;
            r_out_data  <= '0;
`ifdef AES_HOST_TIMEOUT_EN
            r_tmo       <= '0;
            r_out_err   <= 1'b0;
`endif
        end else begin
            r_kexp_prev <= i_io_keyExpReady;
            r_enc_prev  <= i_io_encIntf_cipher_valid;
            r_dec_prev  <= i_io_decIntf_text_valid;
            r_start     <= 1'b0;
            // Saturating countdown; a load in RESP below overrides this.
            if (r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end
            case (r_state)
                S_NOKEY: begin
                    if (i_key_load) begin
                        r_key   <= i_key_in;
                        r_start <= 1'b1;
                        r_state <= S_KEYSTART;
                    end
                end
                S_KEYSTART: begin
                    r_state <= S_KEYWAIT;
`ifdef AES_HOST_TIMEOUT_EN
                    r_tmo   <= '0;
`endif
                end
                S_KEYWAIT: begin
                    if (w_kexp_edge) begin
                        r_state <= S_READY;
                    end
`ifdef AES_HOST_TIMEOUT_EN
                    else if (r_tmo == TMO_LAST) begin
                        r_state <= S_NOKEY;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                end
                S_READY: begin
                    if (i_key_load) begin
                        r_key   <= i_key_in;
                        r_start <= 1'b1;
                        r_state <= S_KEYSTART;
                    end else if (i_in_valid && w_in_ready) begin
                        r_mode <= i_in_mode;
                        if (i_in_mode) begin
                            r_dec_valid <= 1'b1;
                            r_dec_bits  <= i_in_data;
                        end else begin
                            r_enc_valid <= 1'b1;
                            r_enc_bits  <= i_in_data;
                        end
                        r_state <= S_ISSUE;
`ifdef AES_HOST_TIMEOUT_EN
                        r_tmo   <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    if (w_resp_edge) begin
                        r_enc_valid <= 1'b0;
                        r_dec_valid <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_mode  <= r_mode;
                        r_out_data  <= w_resp_bits;
                        r_state     <= S_RESP;
                    end
`ifdef AES_HOST_TIMEOUT_EN
                    else if (r_tmo == TMO_LAST) begin
                        r_enc_valid <= 1'b0;
                        r_dec_valid <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_mode  <= r_mode;
                        r_out_data  <= '0;
                        r_out_err   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
`ifdef AES_HOST_TIMEOUT_EN
                        r_out_err   <= 1'b0;
`endif
                        r_gap       <= GW'(GAP_CYCLES);
                        r_state     <= S_READY;
                    end
                end
                default: r_state <= S_NOKEY;
            endcase
        end
    end

    assign o_in_ready                 = w_in_ready;
    assign o_out_valid                = r_out_valid;
    assign o_out_mode                 = r_out_mode;
    assign o_out_data                 = r_out_data;
    assign o_io_key                   = r_key;
    assign o_io_startKeyExp           = r_start;
    assign o_io_encIntf_text_valid    = r_enc_valid;
    assign o_io_encIntf_text_bits_0   = r_enc_bits;
    assign o_io_decIntf_cipher_valid  = r_dec_valid;
    assign o_io_decIntf_cipher_bits_0 = r_dec_bits;

endmodule

// File: tb/tb_aes_host_sequencer.sv
// tb/tb_aes_host_sequencer.sv - scoreboard bench for aes_host_sequencer with a stub engine

module tb_aes_host_sequencer;

    localparam logic [127:0] K1  = 128'h0123456789abcdef0123456789abcdef;
    localparam logic [127:0] K2  = 128'hfedcba9876543210fedcba9876543210;
    localparam logic [127:0] A5  = {16{8'hA5}};

    logic         clk;
    logic         rst;
    logic         key_load;
    logic [127:0] key_in;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_mode;
    logic [127:0] out_data;
    logic         out_err;
    logic [127:0] io_key;
    logic         start_kexp;
    logic         kexp_ready;
    logic         enc_v;
    logic [127:0] enc_b;
    logic         enc_rv;
    logic [127:0] enc_rb;
    logic         dec_v;
    logic [127:0] dec_b;
    logic         dec_rv;
    logic [127:0] dec_rb;

    logic         mute;
    int           kcnt;
    int           ecnt;
    int           dcnt;

    int           n_run;
    int           n_fail;
    logic [129:0] sb[$];

    aes_host_sequencer #(.GAP_CYCLES(10), .TIMEOUT_CYCLES(64)) dut (
        .i_clock                    (clk),
        .i_reset                    (rst),
        .i_key_load                 (key_load),
        .i_key_in                   (key_in),
        .i_in_valid                 (in_valid),
        .o_in_ready                 (in_ready),
        .i_in_mode                  (in_mode),
        .i_in_data                  (in_data),
        .o_out_valid                (out_valid),
        .i_out_ready                (out_ready),
        .o_out_mode                 (out_mode),
        .o_out_data                 (out_data),
        .o_out_err                  (out_err),
        .o_io_key                   (io_key),
        .o_io_startKeyExp           (start_kexp),
        .i_io_keyExpReady           (kexp_ready),
        .o_io_encIntf_text_valid    (enc_v),
        .o_io_encIntf_text_bits_0   (enc_b),
        .i_io_encIntf_cipher_valid  (enc_rv),
        .i_io_encIntf_cipher_bits_0 (enc_rb),
        .o_io_decIntf_cipher_valid  (dec_v),
        .o_io_decIntf_cipher_bits_0 (dec_b),
        .i_io_decIntf_text_valid    (dec_rv),
        .i_io_decIntf_text_bits_0   (dec_rb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub engine: keyExpReady rises 12 cycles after the start pulse, a response
    // rises 20 cycles after the request valid and falls once the request drops.
    always @(posedge clk) begin
        if (start_kexp) begin
            kcnt       <= 12;
            kexp_ready <= 1'b0;
        end else if (kcnt != 0) begin
            kcnt <= kcnt - 1;
            if (kcnt == 1) kexp_ready <= 1'b1;
        end
        if (enc_v) begin
            if (ecnt < 19) ecnt <= ecnt + 1;
            else if (!mute) begin
                enc_rv <= 1'b1;
                enc_rb <= enc_b ^ A5;
            end
        end else begin
            ecnt   <= 0;
            enc_rv <= 1'b0;
        end
        if (dec_v) begin
            if (dcnt < 19) dcnt <= dcnt + 1;
            else if (!mute) begin
                dec_rv <= 1'b1;
                dec_rb <= dec_b ^ A5;
            end
        end else begin
            dcnt   <= 0;
            dec_rv <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [129:0] act, input logic [129:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [129:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_run++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %h want no output", {out_err, out_mode, out_data});
                end else begin
                    e = sb.pop_front();
                    chk("sb_result", {out_err, out_mode, out_data}, e);
                end
            end
        end
    endtask

    // Presents a block and returns #1 after the accepting edge; waited = cycles spent.
    task automatic send(input logic mode, input logic [127:0] d, output int waited);
        in_mode  = mode;
        in_data  = d;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk("accept", {129'd0, in_ready}, 130'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1 chk(name, 130'(sb.size()), 130'd0);
    endtask

    initial begin
        int  n;
        int  lat;
        int  cnt;
        logic bad;

        n_run = 0; n_fail = 0;
        rst = 1'b1; key_load = 1'b0; key_in = '0; in_valid = 1'b0; in_mode = 1'b0;
        in_data = '0; out_ready = 1'b1; mute = 1'b0;
        kcnt = 0; ecnt = 0; dcnt = 0; kexp_ready = 1'b0;
        enc_rv = 1'b0; enc_rb = '0; dec_rv = 1'b0; dec_rb = '0;
        fork monitor(); join_none
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {123'd0, in_ready, out_valid, out_err, out_mode, start_kexp, enc_v, dec_v}, 130'd0);
        chk("reset_key", {2'b0, io_key}, 130'd0);
        chk("reset_data", {2'b0, out_data}, 130'd0);
        rst = 1'b0;

        // 1: command before any key
        in_valid = 1'b1; in_data = 128'h1; bad = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
            if (in_ready || enc_v || dec_v) bad = 1'b1;
        end
        in_valid = 1'b0;
        chk("t1_nokey_idle", {129'd0, bad}, 130'd0);

        // 2: initial key load
        key_in = K1; key_load = 1'b1;
        @(posedge clk); #1 key_load = 1'b0;
        chk("t2_ready_keystart", {129'd0, in_ready}, 130'd0);
        cnt = start_kexp ? 1 : 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (start_kexp) cnt++;
        end
        chk("t2_start_pulses", 130'(cnt), 130'd1);
        chk("t2_io_key", {2'b0, io_key}, {2'b0, K1});
        chk("t2_ready", {128'd0, in_ready, kexp_ready}, 130'd3);

        // 3: encrypt block, latency accept -> out_valid is 20 + 1
        sb.push_back({1'b0, 1'b0, 128'ha5b48796e1f0c3d22d3c0f1e69784b5a});
        send(1'b0, 128'h00112233445566778899aabbccddeeff, n);
        chk("t3_enc_chan", {enc_v, dec_v, enc_b}, {2'b10, 128'h00112233445566778899aabbccddeeff});
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("t3_latency", 130'(lat), 130'd21);
        drain("t3_drain");
        chk("t3_chan_drop", {128'd0, enc_v, dec_v}, 130'd0);

        // 4: decrypt block with back-pressure, then gap to next in_ready
        out_ready = 1'b0;
        sb.push_back({1'b0, 1'b1, {16{8'hda}}});
        send(1'b1, {16{8'h7f}}, n);
        chk("t4_dec_chan", {enc_v, dec_v, dec_b}, {2'b01, {16{8'h7f}}});
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        bad = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (!out_valid || out_data !== {16{8'hda}} || out_mode !== 1'b1) bad = 1'b1;
        end
        chk("t4_stable", {129'd0, bad}, 130'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t4_gap", 130'(n), 130'd10);
        chk("t4_drain", 130'(sb.size()), 130'd0);

        // 5: key_load and in_valid together in READY
        @(negedge clk);
        key_in = K2; key_load = 1'b1; in_mode = 1'b0; in_data = '0; in_valid = 1'b1;
        #1 chk("t5_ready_drop", {129'd0, in_ready}, 130'd0);
        @(posedge clk); #1 key_load = 1'b0;
        chk("t5_rekey", {enc_v, start_kexp, io_key}, {2'b01, K2});
        sb.push_back({1'b0, 1'b0, A5});
        send(1'b0, '0, n);
        chk("t5_after_edge", {128'd0, kexp_ready, 1'(n >= 12)}, 130'd3);
        drain("t5_drain");

`ifdef AES_HOST_TIMEOUT_EN
        // 6: engine never answers
        mute = 1'b1;
        sb.push_back({1'b1, 1'b0, 128'd0});
        send(1'b0, 128'h1234, n);
        drain("t6_timeout");
        chk("t6_chan_drop", {128'd0, enc_v, dec_v}, 130'd0);
`endif

        // 7: reset in the middle of ISSUE
        mute = 1'b1;
        send(1'b1, 128'h55, n);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("t7_reset_ctrl", {123'd0, in_ready, out_valid, out_err, out_mode, start_kexp, enc_v, dec_v}, 130'd0);
        chk("t7_reset_key", {2'b0, io_key}, 130'd0);
        rst = 1'b0; mute = 1'b0;
        bad = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid || in_ready || dec_v) bad = 1'b1;
        end
        chk("t7_no_partial", {129'd0, bad}, 130'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
